rv32_mmu_arbiter: RTL

- Shares the single rv32 address-translation unit between the instruction-fetch (I) and load/store (D) requesters.
- Accepts one translation request at a time over valid/ready, drives the MMU's en/addr_in, waits the MMU's fixed latency, then returns the physical address to the owner over valid/ready.
- Arbitration between simultaneous requesters is 2-way round-robin.
- Sits between the core's fetch/LSU front ends and rv32_mmu.

---
 rtl/rv32_mmu_pkg.sv | 7 +
 rtl/rv32_rr_arb2.sv | 10 +
 rtl/rv32_mmu_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/rv32_mmu_pkg.sv
// rv32_mmu_pkg: shared types and constants for the MMU request arbiter
package rv32_mmu_pkg;
  localparam int VADDR_W = 32;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rv32_rr_arb2.sv
// rv32_rr_arb2: two-way round-robin picker; bit 0 is I, bit 1 is D
module rv32_rr_arb2
  import rv32_mmu_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);
  always_comb o_gnt = (&i_req) ? ((i_last_grant == REQ_D) ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/rv32_mmu_arbiter.sv
// rv32_mmu_arbiter: shares one translation unit between fetch and load/store requesters
module rv32_mmu_arbiter
  import rv32_mmu_pkg::*;
#(
  parameter int MMU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               xlat_en,
  input  logic               i_req_valid,
  output logic               i_req_ready,
  input  logic [VADDR_W-1:0] i_req_vaddr,
  output logic               i_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [VADDR_W-1:0] i_rsp_paddr,
  output logic               i_rsp_fault,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic [VADDR_W-1:0] d_req_vaddr,
  output logic               d_rsp_valid,
  input  logic               d_rsp_ready,
  output logic [VADDR_W-1:0] d_rsp_paddr,
  output logic               d_rsp_fault,
  output logic               mmu_en,
  output logic [VADDR_W-1:0] mmu_addr_in,
  input  logic [VADDR_W-1:0] mmu_addr_out,
  input  logic               mmu_mem_en,
  output logic               busy
);
  localparam int CW = $clog2(MMU_LATENCY + 1);
  state_t             r_state, w_state_nxt;
  logic               r_owner, r_xlat, r_fault, r_last;
  logic [VADDR_W-1:0] r_vaddr, r_paddr;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         w_gnt;
  logic               w_idle, w_req_hs, w_rsp_hs, w_mmu_act, w_capture;
  rv32_rr_arb2 u_arb (
    .i_req       ({d_req_valid, i_req_valid}),
    .i_last_grant(r_last),
    .o_gnt       (w_gnt)
  );
  // ready is gated by rst_n so every output reads 0 while reset is held
  assign w_idle      = (r_state == IDLE) && rst_n;
  assign i_req_ready = w_idle && w_gnt[0];
  assign d_req_ready = w_idle && w_gnt[1];
  assign w_req_hs    = i_req_ready || d_req_ready;
  assign w_rsp_hs    = (r_state == RESP) && ((r_owner == REQ_D) ? d_rsp_ready : i_rsp_ready);
  assign w_capture   = (r_state == WAIT) && (r_cnt == '0);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_req_hs ? ISSUE : IDLE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = w_capture ? RESP : WAIT;
      RESP:    w_state_nxt = w_rsp_hs ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= REQ_I;
      r_xlat  <= 1'b0;
      r_vaddr <= '0;
      r_paddr <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
      r_last  <= REQ_D;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_vaddr <= w_gnt[1] ? d_req_vaddr : i_req_vaddr;
        r_owner <= w_gnt[1] ? REQ_D : REQ_I;
        r_xlat  <= xlat_en;
      end
      if (r_state == ISSUE) r_cnt <= CW'(MMU_LATENCY - 1);
      else if ((r_state == WAIT) && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_paddr <= mmu_addr_out;
        r_fault <= ~mmu_mem_en;
      end
      if (w_rsp_hs) r_last <= r_owner;
    end
  end
  assign w_mmu_act   = (r_state == ISSUE) || (r_state == WAIT);
  assign mmu_en      = w_mmu_act && r_xlat;
  assign mmu_addr_in = w_mmu_act ? r_vaddr : '0;
  assign i_rsp_valid = (r_state == RESP) && (r_owner == REQ_I);
  assign d_rsp_valid = (r_state == RESP) && (r_owner == REQ_D);
  assign i_rsp_paddr = i_rsp_valid ? r_paddr : '0;
  assign d_rsp_paddr = d_rsp_valid ? r_paddr : '0;
  assign i_rsp_fault = i_rsp_valid && r_fault;
  assign d_rsp_fault = d_rsp_valid && r_fault;
  assign busy        = r_state != IDLE;
endmodule
